// File: rtl/permutation_ctrl.sv
// Round sequencer for an Ascon permutation: p^a (12 rounds) or p^b.
// Build option: define ASCON_PB8_EN for 8-round p^b, else 6-round p^b.
module permutation_ctrl (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       en_o,
  output logic       busy_o,
  output logic       done_o
);

`ifdef ASCON_PB8_EN
  localparam logic [3:0] PbStart = 4'd4;
`else
  localparam logic [3:0] PbStart = 4'd6;
`endif
  localparam logic [3:0] PaStart = 4'd0;
  localparam logic [3:0] LastRnd = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [3:0] start_rnd;

  assign start_rnd = mode_i ? PbStart : PaStart;

  // State, counter and latched mode registers
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; a single-round run would skip RUN entirely
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (start_i) begin
          mode_d  = mode_i;
          cnt_d   = start_rnd;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if ((mode_q ? PbStart : PaStart) == LastRnd) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LastRnd) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    select_o = 1'b0;
    round_o  = 4'd0;
    en_o     = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      FIRST: begin
        select_o = 1'b1;
        round_o  = cnt_q;
        en_o     = 1'b1;
        busy_o   = 1'b1;
      end
      RUN: begin
        round_o = cnt_q;
        en_o    = 1'b1;
        busy_o  = 1'b1;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/permutation_ctrl.md
PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

Interface
REQ-001 SHALL provide ports, one per line: name  direction  width  meaning.
- clock_i  in  1  single clock, all state updates on rising edge
- resetb_i  in  1  asynchronous active-low reset
- start_i  in  1  request one permutation run; sampled only in IDLE
- mode_i  in  1  0 = p^a (12 rounds); 1 = p^b (round count per REQ-020/REQ-021); sampled with start_i
- select_o  out  1  to permutation select_i; 1 = load external state, 0 = feed back registered state
- round_o  out  4  to permutation round_i; round-constant index 0..11
- en_o  out  1  permutation register enable; 1 on every cycle a round is computed
- busy_o  out  1  run in progress (FIRST or RUN)
- done_o  out  1  one-cycle pulse; permutation output is final

REQ-002 SHALL use no parameters; round count is fixed by mode_i and REQ-020/REQ-021.

Function
REQ-003 SHALL implement the FSM states IDLE, FIRST, RUN and DONE.
REQ-004 In IDLE with start_i=1 at a rising edge: SHALL latch mode_i, load the round counter with S = 12-N, and enter FIRST.
REQ-005 In IDLE with start_i=0: SHALL stay in IDLE.
REQ-006 In FIRST: SHALL drive select_o=1, en_o=1, busy_o=1 and round_o=S, then advance to RUN with counter S+1.
- Exception: if N=1, which cannot occur with the supported modes, SHALL go directly to DONE.
REQ-007 In RUN: SHALL drive select_o=0, en_o=1, busy_o=1 and round_o=counter.
- Counter increments by 1 per cycle.
- When counter=11, SHALL go to DONE on the next edge.
REQ-008 SHALL make en_o high for exactly N consecutive cycles per run (1 FIRST + N-1 RUN); round_o SHALL take S, S+1, ..., 11 in order.
REQ-009 In DONE: SHALL drive done_o=1, en_o=0, busy_o=0 and select_o=0, then return to IDLE unconditionally.
REQ-010 Latency: SHALL assert done_o exactly N+1 cycles after the edge at which start_i was sampled.
REQ-011 start_i SHALL be ignored in FIRST, RUN and DONE; there is no queuing. The earliest back-to-back start is the cycle after DONE.
REQ-012 A mode_i change during a run SHALL have no effect; the latched value governs the run.
REQ-013 round_o SHALL never exceed 11; the counter is 4 bits and SHALL never wrap.
REQ-014 In IDLE, outputs SHALL be select_o=0, en_o=0, busy_o=0, done_o=0 and round_o=0.
REQ-015 All outputs SHALL be decoded from registered state only, with no combinational path from start_i or mode_i.

Reset
REQ-016 resetb_i=0 SHALL asynchronously force state IDLE and counter 0, regardless of the clock.
REQ-017 During reset, outputs SHALL be select_o=0, round_o=0, en_o=0, busy_o=0 and done_o=0.
REQ-018 Reset asserted mid-run SHALL abort the run with no done_o pulse. After release, the block SHALL wait in IDLE for a fresh start_i.
REQ-019 The first start_i SHALL be honoured at the first rising edge after resetb_i deasserts.

Configuration
REQ-020 Macro ASCON_PB8_EN defined: mode_i=1 SHALL select N=8, S=4 (Ascon-128a p^b).
REQ-021 Macro ASCON_PB8_EN undefined: mode_i=1 SHALL select N=6, S=6 (Ascon-128 p^b).
REQ-022 mode_i=0 SHALL give N=12, S=0 in both builds; the port list SHALL be identical in both builds.

Verification
REQ-023 p^a run: reset, then start_i=1 with mode_i=0 for one cycle -> select_o=1 for 1 cycle; round_o=0..11 over 12 en_o cycles; done_o on cycle 13.
- With the permutation attached and input 80400c0600000000/0001020304050607/08090a0b0c0d0e0f/0011223344556677/8899aabbccddeeff, the state at done_o SHALL match the golden model.
REQ-024 p^b run, macro undefined: mode_i=1 -> round_o=6..11 over 6 cycles; done_o 7 cycles after start.
- Same run with ASCON_PB8_EN defined: round_o=4..11; done_o after 9 cycles.
REQ-025 start_i held high continuously with mode_i=0 -> runs repeat every 14 cycles (13 run cycles + 1 IDLE).
- Extra start_i during busy_o SHALL be ignored.
REQ-026 Mid-run reset: resetb_i=0 asynchronously when round_o=5 -> all outputs 0 immediately; no done_o.
- Next start_i after release SHALL yield round_o=0.
REQ-027 mode_i toggled from 0 to 1 at round_o=3 -> run continues to round_o=11 with 12 en_o cycles.
